// File: rtl/clk_pkg.sv
// rtl/clk_pkg.sv - shared lock-state type and divided-clock constants
package clk_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } lock_state_t;

    localparam int NOM_PERIOD_16M_TO_1M6 = 10;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - multi-flop synchroniser with registered rise/fall strobes
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_16_384m,
    input  logic rst_n,
    input  logic din,
    output logic rise_nxt,
    output logic rise_en,
    output logic fall_en
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist;
    logic                   sync_bit;
    logic                   fall_nxt;

    assign sync_bit = sync_q[SYNC_STAGES-1];
    // rise_nxt leads rise_en by one cycle so the owner can update state in step with the strobe
    assign rise_nxt = sync_bit & ~hist;
    assign fall_nxt = ~sync_bit & hist;

    always_ff @(posedge clk_16_384m or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            hist    <= 1'b0;
            rise_en <= 1'b0;
            fall_en <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
            hist    <= sync_bit;
            rise_en <= rise_nxt;
            fall_en <= fall_nxt;
        end
    end

endmodule

// File: rtl/clk_en_recover.sv
// rtl/clk_en_recover.sv - divided-clock to enable-strobe recovery with period lock; CLK_EN_RECOVER_DUTY_EN adds duty measurement
module clk_en_recover
    import clk_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int NOM_PERIOD  = NOM_PERIOD_16M_TO_1M6,
    parameter int TOL         = 1,
    parameter int LOCK_CNT    = 4
) (
    input  logic             clk_16_384m,
    input  logic             rst_n,
    input  logic             clk_in,
    output logic             rise_en,
    output logic             fall_en,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             locked,
    output logic             lost
`ifdef CLK_EN_RECOVER_DUTY_EN
    ,
    output logic [CNT_W-1:0] high_time,
    output logic             duty_err
`endif
);

    localparam int GC_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] GOOD_LO  = CNT_W'(NOM_PERIOD - TOL);
    localparam logic [CNT_W-1:0] GOOD_HI  = CNT_W'(NOM_PERIOD + TOL);
    localparam logic [CNT_W-1:0] TIMEOUT  = CNT_W'(2 * NOM_PERIOD);
    localparam logic [GC_W-1:0]  GC_LAST  = GC_W'(LOCK_CNT - 1);

    logic             rise_nxt;
    logic             gap_good;
    logic [CNT_W-1:0] gap_cnt;
    logic [GC_W-1:0]  good_cnt;
    lock_state_t      state;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk_16_384m (clk_16_384m),
        .rst_n       (rst_n),
        .din         (clk_in),
        .rise_nxt    (rise_nxt),
        .rise_en     (rise_en),
        .fall_en     (fall_en)
    );

    assign gap_good = (gap_cnt >= GOOD_LO) && (gap_cnt <= GOOD_HI);

    always_ff @(posedge clk_16_384m or negedge rst_n) begin
        if (!rst_n) begin
            state      <= UNLOCKED;
            gap_cnt    <= '0;
            good_cnt   <= '0;
            period     <= '0;
            period_vld <= 1'b0;
            locked     <= 1'b0;
            lost       <= 1'b0;
        end else begin
            period_vld <= 1'b0;
            locked     <= (state == LOCKED);
            if (gap_cnt != '1)
                gap_cnt <= gap_cnt + 1'b1;

            if (rise_nxt) begin
                gap_cnt <= CNT_W'(1);
                lost    <= 1'b0;
                if (state == UNLOCKED) begin
                    // first edge after reset or loss has no valid reference
                    state    <= ACQUIRE;
                    good_cnt <= '0;
                end else begin
                    period     <= gap_cnt;
                    period_vld <= 1'b1;
                    if (!gap_good) begin
                        state    <= ACQUIRE;
                        good_cnt <= '0;
                    end else if (state == ACQUIRE) begin
                        good_cnt <= good_cnt + 1'b1;
                        if (good_cnt == GC_LAST)
                            state <= LOCKED;
                    end
                end
            end else if (state != UNLOCKED && gap_cnt > TIMEOUT) begin
                // loss only counts once an edge has been seen
                state    <= UNLOCKED;
                good_cnt <= '0;
                lost     <= 1'b1;
                locked   <= 1'b0;
            end
        end
    end

`ifdef CLK_EN_RECOVER_DUTY_EN
    localparam logic [CNT_W-1:0] DUTY_LO = CNT_W'(NOM_PERIOD / 2 - TOL);
    localparam logic [CNT_W-1:0] DUTY_HI = CNT_W'(NOM_PERIOD / 2 + TOL);

    logic [CNT_W-1:0] high_meas;

    // gap_cnt is one ahead of the rise-to-fall distance when fall_en is high
    assign high_meas = gap_cnt - 1'b1;

    always_ff @(posedge clk_16_384m or negedge rst_n) begin
        if (!rst_n) begin
            high_time <= '0;
            duty_err  <= 1'b0;
        end else if (fall_en) begin
            high_time <= high_meas;
            duty_err  <= (high_meas < DUTY_LO) || (high_meas > DUTY_HI);
        end
    end
`endif

endmodule
